// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the command sequencer slice.
//   command_t    : trace entry; n[3:0] is the opcode, addr is the target address
//   OP_*         : opcode values understood by the sequencer
//   seq_state_t  : dispatcher FSM state encoding
//   op_class_t   : which cache channel(s) an opcode targets
//   CMD_RESET    : value presented on instruction while in reset
package cmd_sequencer_pkg;

    typedef struct packed {
        logic [3:0]  n;
        logic [31:0] addr;
    } command_t;

    localparam logic [3:0] OP_READ_D    = 4'd0;
    localparam logic [3:0] OP_WRITE_D   = 4'd1;
    localparam logic [3:0] OP_READ_I    = 4'd2;
    localparam logic [3:0] OP_SNOOP_INV = 4'd3;
    localparam logic [3:0] OP_SNOOP_RD  = 4'd4;
    localparam logic [3:0] OP_CLEAR     = 4'd8;
    localparam logic [3:0] OP_PRINT     = 4'd9;

    typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT_ACK} seq_state_t;

    typedef enum logic [1:0] {OPC_ILLEGAL, OPC_DATA, OPC_INSTR, OPC_ALL} op_class_t;

    localparam command_t CMD_RESET = '{n: 4'b1000, addr: 32'h0};

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        case (op)
            OP_READ_D, OP_WRITE_D, OP_SNOOP_INV, OP_SNOOP_RD: c = OPC_DATA;
            OP_READ_I:                                        c = OPC_INSTR;
            OP_CLEAR, OP_PRINT:                               c = OPC_ALL;
            default:                                          c = OPC_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmd_sequencer_fifo.sv
// Circular command queue with show-ahead read data.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full)
//   pop      : advance head (ignored when empty)
//   wdata    : entry to enqueue
//   rdata    : current head entry (valid when !empty)
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Command queue and two-phase dispatcher for the I/D cache cluster.
//   clk, rst     : clock, asynchronous active-high reset
//   push_valid   : push_cmd valid; accepted when push_ready
//   push_ready   : queue not full
//   push_cmd     : trace command to enqueue
//   run          : enables dispatch
//   step_mode    : dispatch one command per step pulse while idle
//   step         : single-cycle step pulse
//   instruction  : command currently presented to the caches
//   write_enable : WRITE phase strobe
//   read_enable  : READ phase strobe
//   chan_sel     : target channel mask of the current command
//   ack          : per-channel completion pulses
//   busy         : FSM not IDLE
//   count        : queued entries
//   issued_cnt   : retired commands (saturating)
//   err_cnt      : illegal opcodes plus timeouts (saturating)
// Handshake: a push transfers on a clock edge where push_valid && push_ready;
// push_cmd must be stable while push_valid is high.
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  command_t                   push_cmd,
    input  logic                       run,
    input  logic                       step_mode,
    input  logic                       step,
    output command_t                   instruction,
    output logic                       write_enable,
    output logic                       read_enable,
    output logic [CHANNELS-1:0]        chan_sel,
    input  logic [CHANNELS-1:0]        ack,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           issued_cnt,
    output logic [CNT_W-1:0]           err_cnt
);
    localparam int TW = $clog2(TIMEOUT+1);

    seq_state_t          state;
    seq_state_t          state_next;
    seq_state_t          dispatch_target;
    logic [$bits(command_t)-1:0] head_bits;
    command_t            head;
    op_class_t           head_class;
    logic [CHANNELS-1:0] head_mask;
    logic                full;
    logic                empty;
    logic [CHANNELS-1:0] ack_mask;
    logic [TW-1:0]       timer;
    logic                can_go;
    logic                idle_go;
    logic                chain_go;
    logic                dispatch;
    logic                illegal_pop;
    logic                done;
    logic                timeout_ev;
    logic                retire;
    logic [1:0]          err_inc;
    logic [CNT_W:0]      err_sum;

    cmd_fifo #(.DEPTH(DEPTH), .W($bits(command_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_valid),
        .pop   (dispatch),
        .wdata (push_cmd),
        .rdata (head_bits),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign push_ready = !full;
    assign head       = command_t'(head_bits);
    assign head_class = op_class(head.n);

    always_comb begin
        head_mask = '0;
        case (head_class)
            OPC_DATA:  head_mask = CHANNELS'(1);
            OPC_INSTR: head_mask = CHANNELS'(2);
            OPC_ALL:   head_mask = '1;
            default:   head_mask = '0;
        endcase
    end

    // An ack arriving in the same cycle as the completion check counts.
    assign done       = ((ack_mask | ack) & chan_sel) == chan_sel;
    assign timeout_ev = (state == WAIT_ACK) && !done && (timer == TW'(TIMEOUT-1));
    assign retire     = (state == WAIT_ACK) && (done || timeout_ev);

    // Retiring can pop the next command in the same cycle, giving the
    // 3-cycle WRITE/READ/WAIT_ACK cadence. In step mode every dispatch
    // needs a step pulse while idle, so chaining is disabled there.
    assign can_go      = !empty && run;
    assign idle_go     = (state == IDLE) && can_go && (!step_mode || step);
    assign chain_go    = retire && can_go && !step_mode;
    assign dispatch    = idle_go || chain_go;
    assign illegal_pop = dispatch && (head_class == OPC_ILLEGAL);

    always_comb begin
        dispatch_target = WRITE;
        if (head_class == OPC_ILLEGAL) dispatch_target = IDLE;
        else if (head.n == OP_PRINT)   dispatch_target = READ;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (dispatch) state_next = dispatch_target;
            WRITE:    state_next = READ;
            READ:     state_next = WAIT_ACK;
            WAIT_ACK: if (retire) state_next = dispatch ? dispatch_target : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        write_enable = (state == WRITE);
        read_enable  = (state == READ);
        busy         = (state != IDLE);
    end

    assign err_inc = {1'b0, timeout_ev} + {1'b0, illegal_pop};
    assign err_sum = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, err_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= CMD_RESET;
            chan_sel    <= '0;
            ack_mask    <= '0;
            timer       <= '0;
            issued_cnt  <= '0;
            err_cnt     <= '0;
        end else begin
            // Illegal opcodes are discarded without touching the presented command.
            if (dispatch && !illegal_pop) begin
                instruction <= head;
                chan_sel    <= head_mask;
            end
            if (state == READ) begin
                ack_mask <= ack;
                timer    <= '0;
            end else if (state == WAIT_ACK) begin
                ack_mask <= ack_mask | ack;
                timer    <= timer + TW'(1);
            end
            if (retire && issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
            err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed testbench for cmd_sequencer (DEPTH=16, CHANNELS=2, TIMEOUT=64, CNT_W=16).
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    command_t    push_cmd;
    logic        run;
    logic        step_mode;
    logic        step;
    command_t    instruction;
    logic        write_enable;
    logic        read_enable;
    logic [1:0]  chan_sel;
    logic [1:0]  ack;
    logic        busy;
    logic [4:0]  count;
    logic [15:0] issued_cnt;
    logic [15:0] err_cnt;

    int tests = 0;
    int fails = 0;
    logic [$bits(command_t)-1:0] exp_q[$];

    cmd_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_cmd     (push_cmd),
        .run          (run),
        .step_mode    (step_mode),
        .step         (step),
        .instruction  (instruction),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .chan_sel     (chan_sel),
        .ack          (ack),
        .busy         (busy),
        .count        (count),
        .issued_cnt   (issued_cnt),
        .err_cnt      (err_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; push_valid = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0; ack = 2'b00;
        push_cmd = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_for_we(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (write_enable) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (instruction !== CMD_RESET) begin fails++; $display("FAIL reset_instr: got %h want %h", instruction, CMD_RESET); end
        tests++; if (write_enable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", write_enable); end
        tests++; if (read_enable !== 1'b0) begin fails++; $display("FAIL reset_re: got %b want 0", read_enable); end
        tests++; if (chan_sel !== 2'b00) begin fails++; $display("FAIL reset_chan: got %b want 00", chan_sel); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (issued_cnt !== 16'd0 || err_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", issued_cnt, err_cnt); end
        tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", push_ready); end
    endtask

    task automatic test_single();
        command_t c;
        c = '{n: OP_READ_D, addr: 32'h984DE132};
        push_cmd = c; push_valid = 1'b1; run = 1'b1;
        tick();
        push_valid = 1'b0;
        tests++; if (write_enable !== 1'b0 || count !== 5'd1) begin fails++; $display("FAIL single_t1: we=%b count=%0d want we=0 count=1", write_enable, count); end
        tick();
        tests++; if (write_enable !== 1'b1 || read_enable !== 1'b0) begin fails++; $display("FAIL single_we_t2: we=%b re=%b want 1/0", write_enable, read_enable); end
        tests++; if (chan_sel !== 2'b01) begin fails++; $display("FAIL single_chan: got %b want 01", chan_sel); end
        tests++; if (instruction !== c) begin fails++; $display("FAIL single_instr: got %h want %h", instruction, c); end
        tick();
        tests++; if (read_enable !== 1'b1 || write_enable !== 1'b0) begin fails++; $display("FAIL single_re_t3: re=%b we=%b want 1/0", read_enable, write_enable); end
        ack = 2'b01;
        tick();
        ack = 2'b00;
        tests++; if (busy !== 1'b1 || read_enable !== 1'b0) begin fails++; $display("FAIL single_wait: busy=%b re=%b want 1/0", busy, read_enable); end
        tick();
        tests++; if (busy !== 1'b0 || issued_cnt !== 16'd1) begin fails++; $display("FAIL single_retire: busy=%b issued=%0d want 0/1", busy, issued_cnt); end
    endtask

    task automatic test_fill_drain();
        command_t c;
        bit done;
        run = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            c = '{n: OP_WRITE_D, addr: 32'h1000 + i};
            exp_q.push_back(c);
            push_cmd = c; push_valid = 1'b1;
            tick();
        end
        push_cmd = '{n: OP_WRITE_D, addr: 32'hDEAD};
        tests++; if (push_ready !== 1'b0 || count !== 5'd16) begin fails++; $display("FAIL fill_full: ready=%b count=%0d want 0/16", push_ready, count); end
        tick();
        push_valid = 1'b0;
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL fill_17th: count=%0d want 16", count); end
        run = 1'b1;
        done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            ack = read_enable ? 2'b11 : 2'b00;
            if (write_enable) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL drain_extra: got %h want none", instruction);
                end else begin
                    c = command_t'(exp_q.pop_front());
                    if (instruction !== c) begin fails++; $display("FAIL drain_order: got %h want %h", instruction, c); end
                end
            end
            if (exp_q.size() == 0 && !busy && count == 5'd0) done = 1'b1;
            else tick();
        end
        ack = 2'b00;
        tests++; if (!done) begin fails++; $display("FAIL drain_timeout: left=%0d count=%0d want 0/0", exp_q.size(), count); end
        tests++; if (issued_cnt !== 16'd17) begin fails++; $display("FAIL drain_issued: got %0d want 17", issued_cnt); end
    endtask

    task automatic test_channels();
        bit ok;
        command_t c1, c2;
        c1 = '{n: OP_READ_I, addr: 32'hA0};
        c2 = '{n: OP_CLEAR, addr: 32'hB0};
        push_cmd = c1; push_valid = 1'b1;
        tick();
        push_cmd = c2;
        tick();
        push_valid = 1'b0;
        wait_for_we(ok);
        tests++; if (!ok || chan_sel !== 2'b10 || instruction !== c1) begin fails++; $display("FAIL chan_instr: ok=%b chan=%b instr=%h want 1/10/%h", ok, chan_sel, instruction, c1); end
        tick();
        ack = 2'b10;
        tick();
        ack = 2'b00;
        wait_for_we(ok);
        tests++; if (!ok || chan_sel !== 2'b11 || instruction !== c2) begin fails++; $display("FAIL chan_clear: ok=%b chan=%b instr=%h want 1/11/%h", ok, chan_sel, instruction, c2); end
        tick();
        tick();
        ack = 2'b01;
        tick();
        ack = 2'b00;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL chan_partial1: busy=%b want 1", busy); end
        tick();
        tests++; if (busy !== 1'b1 || issued_cnt !== 16'd18) begin fails++; $display("FAIL chan_partial2: busy=%b issued=%0d want 1/18", busy, issued_cnt); end
        ack = 2'b10;
        tick();
        ack = 2'b00;
        tests++; if (busy !== 1'b0 || issued_cnt !== 16'd19) begin fails++; $display("FAIL chan_done: busy=%b issued=%0d want 0/19", busy, issued_cnt); end
    endtask

    task automatic test_print_illegal();
        push_cmd = '{n: OP_PRINT, addr: 32'hC0}; push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        tests++; if (write_enable !== 1'b0 || read_enable !== 1'b0) begin fails++; $display("FAIL print_t1: we=%b re=%b want 0/0", write_enable, read_enable); end
        tick();
        tests++; if (read_enable !== 1'b1 || write_enable !== 1'b0 || chan_sel !== 2'b11) begin fails++; $display("FAIL print_read: re=%b we=%b chan=%b want 1/0/11", read_enable, write_enable, chan_sel); end
        ack = 2'b11;
        tick();
        ack = 2'b00;
        tests++; if (read_enable !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL print_wait: re=%b we=%b busy=%b want 0/0/1", read_enable, write_enable, busy); end
        tick();
        tests++; if (busy !== 1'b0 || issued_cnt !== 16'd20) begin fails++; $display("FAIL print_retire: busy=%b issued=%0d want 0/20", busy, issued_cnt); end
        push_cmd = '{n: 4'd6, addr: 32'hC4}; push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        tests++; if (count !== 5'd1 || busy !== 1'b0) begin fails++; $display("FAIL illegal_q: count=%0d busy=%b want 1/0", count, busy); end
        tick();
        tests++; if (count !== 5'd0 || busy !== 1'b0 || write_enable !== 1'b0 || read_enable !== 1'b0) begin fails++; $display("FAIL illegal_pop: count=%0d busy=%b we=%b re=%b want 0/0/0/0", count, busy, write_enable, read_enable); end
        tests++; if (err_cnt !== 16'd1 || issued_cnt !== 16'd20) begin fails++; $display("FAIL illegal_cnt: err=%0d issued=%0d want 1/20", err_cnt, issued_cnt); end
    endtask

    task automatic test_timeout_reset();
        bit ok;
        apply_reset();
        run = 1'b1;
        push_cmd = '{n: OP_READ_D, addr: 32'hD0}; push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        wait_for_we(ok);
        tick();
        tick();
        repeat (63) tick();
        tests++; if (!ok || busy !== 1'b1 || err_cnt !== 16'd0) begin fails++; $display("FAIL timeout_wait64: ok=%b busy=%b err=%0d want 1/1/0", ok, busy, err_cnt); end
        tick();
        tests++; if (busy !== 1'b0 || err_cnt !== 16'd1 || issued_cnt !== 16'd1) begin fails++; $display("FAIL timeout_retire: busy=%b err=%0d issued=%0d want 0/1/1", busy, err_cnt, issued_cnt); end
        push_cmd = '{n: OP_READ_D, addr: 32'hE0}; push_valid = 1'b1;
        tick();
        push_cmd = '{n: OP_READ_D, addr: 32'hE1};
        tick();
        push_valid = 1'b0;
        wait_for_we(ok);
        tick();
        tick();
        tests++; if (!ok || busy !== 1'b1 || count !== 5'd1) begin fails++; $display("FAIL abort_setup: ok=%b busy=%b count=%0d want 1/1/1", ok, busy, count); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || write_enable !== 1'b0 || read_enable !== 1'b0 || chan_sel !== 2'b00) begin fails++; $display("FAIL abort_ctrl: busy=%b we=%b re=%b chan=%b want 0/0/0/00", busy, write_enable, read_enable, chan_sel); end
        tests++; if (instruction !== CMD_RESET || count !== 5'd0 || push_ready !== 1'b1) begin fails++; $display("FAIL abort_q: instr=%h count=%0d ready=%b want %h/0/1", instruction, count, push_ready, CMD_RESET); end
        tests++; if (issued_cnt !== 16'd0 || err_cnt !== 16'd0) begin fails++; $display("FAIL abort_cnts: issued=%0d err=%0d want 0/0", issued_cnt, err_cnt); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_step_and_full();
        run = 1'b1; step_mode = 1'b1; step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd = '{n: OP_WRITE_D, addr: 32'hF0 + i}; push_valid = 1'b1;
            tick();
        end
        push_valid = 1'b0;
        repeat (3) tick();
        tests++; if (count !== 5'd3 || busy !== 1'b0) begin fails++; $display("FAIL step_hold: count=%0d busy=%b want 3/0", count, busy); end
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tests++; if (write_enable !== 1'b1 || count !== 5'(2 - k) || instruction.addr !== 32'hF0 + k) begin fails++; $display("FAIL step_go%0d: we=%b count=%0d addr=%h want 1/%0d/%h", k, write_enable, count, instruction.addr, 2 - k, 32'hF0 + k); end
            tick();
            ack = 2'b01; step = 1'b1;
            tick();
            ack = 2'b00; step = 1'b0;
            tick();
            tests++; if (busy !== 1'b0 || count !== 5'(2 - k) || issued_cnt !== 16'(k + 1)) begin fails++; $display("FAIL step_busy%0d: busy=%b count=%0d issued=%0d want 0/%0d/%0d", k, busy, count, issued_cnt, 2 - k, k + 1); end
        end
        step_mode = 1'b0; run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            push_cmd = '{n: OP_READ_D, addr: 32'h200 + i}; push_valid = 1'b1;
            tick();
        end
        push_valid = 1'b0;
        tests++; if (count !== 5'd15 || push_ready !== 1'b1) begin fails++; $display("FAIL pushpop_setup: count=%0d ready=%b want 15/1", count, push_ready); end
        push_cmd = '{n: OP_READ_D, addr: 32'h2FF}; push_valid = 1'b1; run = 1'b1;
        tick();
        push_valid = 1'b0; run = 1'b0;
        tests++; if (count !== 5'd15 || busy !== 1'b1) begin fails++; $display("FAIL pushpop: count=%0d busy=%b want 15/1", count, busy); end
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0; ack = 2'b00;
        push_cmd = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_channels();
        test_print_illegal();
        test_timeout_reset();
        test_step_and_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
